// File: rtl/dmem_bridge.sv
// dmem_bridge: membuf-to-bus bridge, one access outstanding, IDLE/BUS/RESP FSM.
// Define DMEM_TIMEOUT_EN to add a bus-ack watchdog of TIMEOUT_CYC cycles.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_bridge #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_req,
    input  logic              dmem_cmd,
    input  logic [1:0]        dmem_width,
    input  logic [`XLEN-1:0]  dmem_addr,
    input  logic [`XLEN-1:0]  dmem_wdata,
    output logic [`XLEN-1:0]  dmem_rdata,
    output logic              dmem_resp,
    output logic              dmem_err,
    output logic              bus_cyc,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [`XLEN-1:0]  bus_adr,
    output logic [`XLEN-1:0]  bus_dat_o,
    input  logic [`XLEN-1:0]  bus_dat_i,
    input  logic              bus_ack
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t             state_q, state_d;
    logic               we_q;
    logic               is_word_q;
    logic [1:0]         lane_q;
    logic [3:0]         sel_q, sel_d;
    logic [`XLEN-1:0]   adr_q;
    logic [`XLEN-1:0]   dat_q, dat_d;
    logic [`XLEN-1:0]   rdata_q;
    logic [`XLEN-1:0]   load_d;
    logic               capture;
    logic               timeout_hit;

    // A request arriving while BUS is busy is dropped, not queued.
    assign capture = dmem_req && (state_q != S_BUS);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Ack on the limit cycle takes precedence over the abort.
    assign timeout_hit = (state_q == S_BUS) && !bus_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_BUS) ? cnt_q + 1'b1 : '0;
            err_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dmem_req) state_d = S_BUS;
            S_BUS:   if (bus_ack || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = dmem_req ? S_BUS : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_resp = 1'b0;
        dmem_err  = 1'b0;
        bus_cyc   = 1'b0;
        case (state_q)
            S_BUS:  bus_cyc = 1'b1;
            S_RESP: begin
                dmem_resp = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                dmem_err  = err_q;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        case (dmem_width)
            2'b00:   sel_d = 4'b0001 << dmem_addr[1:0];
            2'b01:   sel_d = 4'b0011 << {dmem_addr[1], 1'b0};
            default: sel_d = 4'b1111;
        endcase
        case (dmem_width)
            2'b00:   dat_d = {(`XLEN/8){dmem_wdata[7:0]}};
            2'b01:   dat_d = {(`XLEN/16){dmem_wdata[15:0]}};
            default: dat_d = dmem_wdata;
        endcase
    end

    // Right-align the addressed lane; sign extension is left to membuf.
    assign load_d = is_word_q ? bus_dat_i : (bus_dat_i >> {lane_q, 3'b000});

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            is_word_q <= 1'b0;
            lane_q    <= 2'b00;
            sel_q     <= 4'b0000;
            adr_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
        end else begin
            if (capture) begin
                we_q      <= dmem_cmd;
                is_word_q <= dmem_width[1];
                lane_q    <= dmem_addr[1:0];
                sel_q     <= sel_d;
                adr_q     <= {dmem_addr[`XLEN-1:2], 2'b00};
                dat_q     <= dat_d;
            end
            if (state_q == S_BUS && bus_ack)
                rdata_q <= we_q ? '0 : load_d;
            else if (timeout_hit)
                rdata_q <= '0;
        end
    end

    assign dmem_rdata = rdata_q;
    assign bus_we     = we_q;
    assign bus_sel    = sel_q;
    assign bus_adr    = adr_q;
    assign bus_dat_o  = dat_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus a random loop,
// responses checked against a scoreboard queue. Timeout cases need DMEM_TIMEOUT_EN.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_dmem_bridge;
    logic              clk = 1'b0;
    logic              rst;
    logic              dmem_req;
    logic              dmem_cmd;
    logic [1:0]        dmem_width;
    logic [`XLEN-1:0]  dmem_addr;
    logic [`XLEN-1:0]  dmem_wdata;
    logic [`XLEN-1:0]  dmem_rdata;
    logic              dmem_resp;
    logic              dmem_err;
    logic              bus_cyc;
    logic              bus_we;
    logic [3:0]        bus_sel;
    logic [`XLEN-1:0]  bus_adr;
    logic [`XLEN-1:0]  bus_dat_o;
    logic [`XLEN-1:0]  bus_dat_i;
    logic              bus_ack;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dmem_err(dmem_err),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel), .bus_adr(bus_adr),
        .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard monitor: every response pops one expectation.
    always @(negedge clk) begin
        if (!rst && dmem_resp) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp rdata=%h err=%b", dmem_rdata, dmem_err);
            end else begin
                mon_e = sb.pop_front();
                if (dmem_rdata !== mon_e.rd || dmem_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL resp_data got rdata=%h err=%b want rdata=%h err=%b",
                             dmem_rdata, dmem_err, mon_e.rd, mon_e.err);
                end
            end
        end else if (!rst) begin
            checks++;
            if (dmem_err !== 1'b0) begin
                errors++;
                $display("FAIL err_without_resp got %b want 0", dmem_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    function automatic logic [3:0] m_sel(input logic [1:0] w, input logic [31:0] a);
        case (w)
            2'b00:   return 4'b0001 << a[1:0];
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_dat(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic c, input logic [1:0] w,
                                         input logic [31:0] a, input logic [31:0] bd);
        if (c) return 32'h0;
        if (w[1]) return bd;
        return bd >> (8 * a[1:0]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic c, input logic [1:0] w,
                             input logic [31:0] a, input logic [31:0] d);
        dmem_req   = 1'b1;
        dmem_cmd   = c;
        dmem_width = w;
        dmem_addr  = a;
        dmem_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_req(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus_ack = 1'b1;
        bus_dat_i = 32'hFFFF_FFFF;
        tick; tick;
        @(negedge clk);
        checks++;
        if ({dmem_resp, dmem_err, bus_cyc, bus_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {dmem_resp, dmem_err, bus_cyc, bus_we});
        end
        checks++;
        if (bus_sel !== 4'b0000 || bus_adr !== 32'h0 || bus_dat_o !== 32'h0 || dmem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got sel=%b adr=%h dat=%h rd=%h want all 0",
                     bus_sel, bus_adr, bus_dat_o, dmem_rdata);
        end
        tick;
        rst = 1'b0;
        dmem_req = 1'b0;
        bus_ack = 1'b0;
        tick;
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_discard got bus_cyc=%b want 0", bus_cyc);
        end
    endtask

    task automatic test_load_byte;
        tick;
        drive_req(1'b0, 2'b00, 32'h0000_1003, 32'h0);
        sb.push_back('{rd: 32'h0000_00AA, err: 1'b0});
        tick;
        dmem_req = 1'b0;
        bus_ack = 1'b1;
        bus_dat_i = 32'hAABB_CCDD;
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b1 || bus_we !== 1'b0 || bus_sel !== 4'b1000 || bus_adr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL load_byte_bus got cyc=%b we=%b sel=%b adr=%h want 1 0 1000 00001000",
                     bus_cyc, bus_we, bus_sel, bus_adr);
        end
        tick;
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b1 || bus_cyc !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_latency got resp=%b cyc=%b want 1 0", dmem_resp, bus_cyc);
        end
        tick;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b0 || dmem_rdata !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL load_byte_hold got resp=%b rd=%h want 0 000000aa", dmem_resp, dmem_rdata);
        end
    endtask

    task automatic test_store_half;
        drive_req(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234);
        sb.push_back('{rd: 32'h0, err: 1'b0});
        tick;
        dmem_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b1 || bus_we !== 1'b1 || bus_sel !== 4'b1100 ||
            bus_dat_o !== 32'h1234_1234 || bus_adr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL store_half_bus got cyc=%b we=%b sel=%b dat=%h adr=%h want 1 1 1100 12341234 00002000",
                     bus_cyc, bus_we, bus_sel, bus_dat_o, bus_adr);
        end
        tick;
        bus_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b1 || dmem_resp !== 1'b0 || bus_sel !== 4'b1100 || bus_dat_o !== 32'h1234_1234) begin
            errors++;
            $display("FAIL store_half_hold got cyc=%b resp=%b sel=%b dat=%h want 1 0 1100 12341234",
                     bus_cyc, dmem_resp, bus_sel, bus_dat_o);
        end
        tick;
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b1) begin
            errors++;
            $display("FAIL store_half_resp got %b want 1", dmem_resp);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        drive_req(1'b0, 2'b10, 32'h0000_3000, 32'h0);
        sb.push_back('{rd: 32'hCAFE_F00D, err: 1'b0});
        tick;
        dmem_req = 1'b0;
        bus_ack = 1'b1;
        bus_dat_i = 32'hCAFE_F00D;
        tick;
        bus_ack = 1'b0;
        drive_req(1'b1, 2'b00, 32'h0000_3005, 32'h0000_005A);
        sb.push_back('{rd: 32'h0, err: 1'b0});
        tick;
        // Protocol violation while BUS: must not disturb the live request.
        drive_req(1'b0, 2'b10, 32'h0000_4000, 32'hFFFF_FFFF);
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b1 || bus_we !== 1'b1 || bus_sel !== 4'b0010 ||
            bus_adr !== 32'h0000_3004 || bus_dat_o !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL b2b_no_gap got cyc=%b we=%b sel=%b adr=%h dat=%h want 1 1 0010 00003004 5a5a5a5a",
                     bus_cyc, bus_we, bus_sel, bus_adr, bus_dat_o);
        end
        tick;
        dmem_req = 1'b0;
        bus_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b1 || bus_we !== 1'b1 || bus_adr !== 32'h0000_3004 || bus_sel !== 4'b0010) begin
            errors++;
            $display("FAIL bus_req_ignored got cyc=%b we=%b adr=%h sel=%b want 1 1 00003004 0010",
                     bus_cyc, bus_we, bus_adr, bus_sel);
        end
        tick;
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_resp got %b want 1", dmem_resp);
        end
        tick;
    endtask

    task automatic test_rst_mid_bus;
        drive_req(1'b0, 2'b10, 32'h0000_5000, 32'h0);
        tick;
        dmem_req = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b0 || dmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_bus got cyc=%b resp=%b want 0 0", bus_cyc, dmem_resp);
        end
        bus_ack = 1'b1;
        bus_dat_i = 32'h1111_1111;
        tick;
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b0 || bus_cyc !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored got resp=%b cyc=%b want 0 0", dmem_resp, bus_cyc);
        end
        drive_req(1'b0, 2'b01, 32'h0000_5002, 32'h0);
        sb.push_back('{rd: 32'h0000_8765, err: 1'b0});
        tick;
        dmem_req = 1'b0;
        bus_ack = 1'b1;
        bus_dat_i = 32'h8765_4321;
        tick;
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_load got resp=%b want 1", dmem_resp);
        end
        tick;
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            logic        c;
            logic [1:0]  w;
            logic [31:0] a, d, bd;
            int          dly;
            c   = 1'($urandom_range(0, 1));
            w   = 2'($urandom_range(0, 3));
            a   = $urandom;
            d   = $urandom;
            bd  = $urandom;
            dly = $urandom_range(0, 2);
            drive_req(c, w, a, d);
            sb.push_back('{rd: m_rd(c, w, a, bd), err: 1'b0});
            tick;
            dmem_req = 1'b0;
            @(negedge clk);
            checks++;
            if (bus_cyc !== 1'b1 || bus_we !== c || bus_sel !== m_sel(w, a) ||
                bus_adr !== {a[31:2], 2'b00} || bus_dat_o !== m_dat(w, d)) begin
                errors++;
                $display("FAIL rand_bus[%0d] got cyc=%b we=%b sel=%b adr=%h dat=%h want 1 %b %b %h %h",
                         i, bus_cyc, bus_we, bus_sel, bus_adr, bus_dat_o,
                         c, m_sel(w, a), {a[31:2], 2'b00}, m_dat(w, d));
            end
            for (int k = 0; k < dly; k++) tick;
            bus_ack = 1'b1;
            bus_dat_i = bd;
            tick;
            bus_ack = 1'b0;
            @(negedge clk);
            checks++;
            if (dmem_resp !== 1'b1) begin
                errors++;
                $display("FAIL rand_resp[%0d] got %b want 1", i, dmem_resp);
            end
            tick;
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout;
        drive_req(1'b0, 2'b10, 32'h0000_6000, 32'h0);
        sb.push_back('{rd: 32'h1234_5678, err: 1'b0});
        tick;
        dmem_req = 1'b0;
        bus_ack = 1'b1;
        bus_dat_i = 32'h1234_5678;
        tick;
        bus_ack = 1'b0;
        tick;
        drive_req(1'b0, 2'b10, 32'h0000_6004, 32'h0);
        sb.push_back('{rd: 32'h0, err: 1'b1});
        tick;
        dmem_req = 1'b0;
        tick; tick; tick;
        @(negedge clk);
        checks++;
        if (bus_cyc !== 1'b1 || dmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait got cyc=%b resp=%b want 1 0", bus_cyc, dmem_resp);
        end
        tick;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b1 || dmem_err !== 1'b1 || bus_cyc !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort got resp=%b err=%b cyc=%b want 1 1 0", dmem_resp, dmem_err, bus_cyc);
        end
        tick;
        drive_req(1'b0, 2'b00, 32'h0000_6001, 32'h0);
        sb.push_back('{rd: 32'h0000_00BB, err: 1'b0});
        tick;
        dmem_req = 1'b0;
        tick; tick; tick;
        bus_ack = 1'b1;
        bus_dat_i = 32'h0000_BB00;
        tick;
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b1 || dmem_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack_wins got resp=%b err=%b want 1 0", dmem_resp, dmem_err);
        end
        tick;
    endtask
`endif

    initial begin
        rst = 1'b1;
        dmem_req = 1'b0;
        dmem_cmd = 1'b0;
        dmem_width = 2'b00;
        dmem_addr = '0;
        dmem_wdata = '0;
        bus_dat_i = '0;
        bus_ack = 1'b0;
        test_reset;
        test_load_byte;
        test_store_half;
        test_back_to_back;
        test_rst_mid_bus;
        test_random;
`ifdef DMEM_TIMEOUT_EN
        test_timeout;
`endif
        tick; tick;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_resp got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
